// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared types and encoding constants for the mcpu_core multicycle CPU.
// Holds the controller state enum, opcode/op/shift codes and instruction field positions.
package mcpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_REG = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam int OPC_LSB = 13;
   localparam int OP_LSB  = 11;
   localparam int RN_LSB  = 8;
   localparam int RD_LSB  = 5;
   localparam int SH_LSB  = 3;
   localparam int RM_LSB  = 0;

endpackage

// File: rtl/mcpu_regfile.sv
// mcpu_regfile: 8 x DATA_W register file, one synchronous write port,
// combinational datapath read (raddr_i/rdata_o) and debug read (dbg_sel_i/dbg_data_o).
module mcpu_regfile #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic [2:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [2:0]        raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   input  logic [2:0]        dbg_sel_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] regs_q [8];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o    = regs_q[raddr_i];
   assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/mcpu_core.sv
// mcpu_core: multicycle 16-bit-instruction CPU (IR, controller FSM, regfile, shifter, ALU, NZV).
// Ports: clk, reset, load, s, in -> out (C), N/Z/V, w, dbg_sel/dbg_data, illegal. Macro: MCPU_ILLEGAL_TRAP_EN.
module mcpu_core
   import mcpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              s,
   input  logic [15:0]       in,
   output logic [DATA_W-1:0] out,
   output logic              N,
   output logic              Z,
   output logic              V,
   output logic              w,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic              illegal
);

   state_t            state_q, state_d;
   logic [15:0]       ir_q;
   logic [DATA_W-1:0] a_q, b_q, c_q;
   logic              n_q, z_q, v_q;

   logic [2:0] opc, rn, rd, rm;
   logic [1:0] op, sh;
   assign opc = ir_q[OPC_LSB +: 3];
   assign op  = ir_q[OP_LSB +: 2];
   assign rn  = ir_q[RN_LSB +: 3];
   assign rd  = ir_q[RD_LSB +: 3];
   assign sh  = ir_q[SH_LSB +: 2];
   assign rm  = ir_q[RM_LSB +: 3];

   logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, legal;
   assign is_mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
   assign is_alu     = (opc == OPC_ALU);
   assign is_cmp     = is_alu && (op == OP_CMP);
   assign is_mvn     = is_alu && (op == OP_MVN);
   assign legal      = is_mov_imm || is_mov_reg || is_alu;

   logic [DATA_W-1:0] sximm;
   assign sximm = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

   logic              rf_we;
   logic [2:0]        rf_waddr, rf_raddr;
   logic [DATA_W-1:0] rf_wdata, rf_rdata;

   assign rf_we    = (state_q == S_WRITE_IMM) || (state_q == S_WRITE_REG);
   assign rf_waddr = (state_q == S_WRITE_IMM) ? rn : rd;
   assign rf_wdata = (state_q == S_WRITE_IMM) ? sximm : c_q;
   assign rf_raddr = (state_q == S_GET_A) ? rn : rm;

   mcpu_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk        (clk),
      .reset      (reset),
      .we_i       (rf_we),
      .waddr_i    (rf_waddr),
      .wdata_i    (rf_wdata),
      .raddr_i    (rf_raddr),
      .rdata_o    (rf_rdata),
      .dbg_sel_i  (dbg_sel),
      .dbg_data_o (dbg_data)
   );

   logic [DATA_W-1:0] b_sh, a_op, alu_r;
   logic              alu_v;

   always_comb begin
      b_sh = b_q;
      unique case (sh)
         SH_NONE: b_sh = b_q;
         SH_LSL:  b_sh = b_q << 1;
         SH_LSR:  b_sh = b_q >> 1;
         SH_ASR:  b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      endcase
   end

   // MOV reg reuses the ADD path with a zero A operand; A is never loaded for it.
   assign a_op = (opc == OPC_MOV) ? '0 : a_q;

   always_comb begin
      alu_r = '0;
      unique case (op)
         OP_ADD: alu_r = a_op + b_sh;
         OP_CMP: alu_r = a_op - b_sh;
         OP_AND: alu_r = a_op & b_sh;
         OP_MVN: alu_r = ~b_sh;
      endcase
   end

   assign alu_v = (a_op[DATA_W-1] != b_sh[DATA_W-1]) &&
                  (alu_r[DATA_W-1] != a_op[DATA_W-1]);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT:      if (s) state_d = S_DECODE;
         S_DECODE: begin
            if (is_mov_imm)                state_d = S_WRITE_IMM;
            else if (is_mov_reg || is_mvn) state_d = S_GET_B;
            else if (is_alu)               state_d = S_GET_A;
`ifdef MCPU_ILLEGAL_TRAP_EN
            else                           state_d = S_HALT;
`else
            else                           state_d = S_WAIT;
`endif
         end
         S_WRITE_IMM: state_d = S_WAIT;
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_EXEC;
         S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_d = S_WAIT;
`ifdef MCPU_ILLEGAL_TRAP_EN
         S_HALT:      state_d = S_HALT;
`else
         S_HALT:      state_d = S_WAIT;
`endif
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_WAIT && load) ir_q <= in;
         if (state_q == S_GET_A) a_q <= rf_rdata;
         if (state_q == S_GET_B) b_q <= rf_rdata;
         if (state_q == S_EXEC) begin
            if (is_cmp) begin
               n_q <= alu_r[DATA_W-1];
               z_q <= (alu_r == '0);
               v_q <= alu_v;
            end else begin
               c_q <= alu_r;
            end
         end
      end
   end

`ifdef MCPU_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (reset) illegal_q <= 1'b0;
      else if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign out = c_q;
   assign N   = n_q;
   assign Z   = z_q;
   assign V   = v_q;
   assign w   = (state_q == S_WAIT);

endmodule
